prog_tick_gen: RTL and testbench

Multi-channel programmable tick generator. Each channel divides clk by a runtime-loadable divisor and emits single-cycle tick pulses, either periodically or once. It replaces fixed compile-time prescalers used for display refresh, sensor polling and debounce timing. Divisors and modes are written over a single-cycle config port with no backpressure.

---
 rtl/prog_tick_gen.sv | 140 ++++++++++++++
 tb/tb_prog_tick_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_tick_gen.sv
// -----------------------------------------------------------------------------
// prog_tick_gen
//
// Multi-channel programmable tick generator. Each channel divides clk by a
// divisor that can be loaded at run time. It emits single-cycle tick pulses,
// either periodically or once (one-shot). Divisors and modes are written over
// a single-cycle config port that has no backpressure.
//
// Optional feature (macro TICK_GEN_SYNC_EN):
//   When defined, a global 'sync' input is added. A pulse on sync zeroes every
//   channel counter, so channels with equal divisors become phase-aligned.
//   When undefined, the port does not exist.
//
// Ports:
//   clk          in   rising-edge clock for all logic
//   reset        in   asynchronous, active-high; clears all state
//   enable       in   [NUM_CH]  per-channel run enable
//   cfg_wr       in   config write strobe, one cycle
//   cfg_ch       in   [CH_W]    target channel of the write
//   cfg_div      in   [CNT_W]   new divisor (0 = channel inert)
//   cfg_oneshot  in   new mode: 1 = one-shot, 0 = periodic
//   sync         in   (TICK_GEN_SYNC_EN only) global counter realignment
//   tick         out  [NUM_CH]  registered single-cycle tick per channel
//   busy         out  [NUM_CH]  registered; channel is in RUN state
// -----------------------------------------------------------------------------
module prog_tick_gen #(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 24,
    parameter  int DEFAULT_DIV = 50000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
`ifdef TICK_GEN_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Global realignment request; constant zero when the feature is absent.
    logic sync_hit;
`ifdef TICK_GEN_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // A channel index wider than NUM_CH-1 never matches any channel, so
        // out-of-range writes fall through without touching any state.
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

        state_t           state_q, state_d;
        logic [CNT_W-1:0] div_q,   div_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic             mode_q,  mode_d;
        logic             tick_q,  tick_d;

        logic cfg_hit;
        logic at_last;

        assign cfg_hit = cfg_wr && (cfg_ch == CH_IDX);
        // When div is 0 this comparison is never used, because an inert
        // channel is handled before the counting branch.
        assign at_last = (count_q == (div_q - CNT_W'(1)));

        // NOTE: every signal this block writes gets a default first, so no
        // path can leave one unassigned and infer a latch.
        always_comb begin
            state_d = state_q;
            div_d   = div_q;
            count_d = count_q;
            mode_d  = mode_q;
            tick_d  = 1'b0;

            if (cfg_hit) begin
                div_d   = cfg_div;
                mode_d  = cfg_oneshot;
                count_d = '0;
                state_d = IDLE;
            end else if (sync_hit) begin
                // Realign: a running channel stays RUN and restarts from zero.
                // A finished one-shot is re-armed.
                count_d = '0;
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end else if (!enable[g] || (div_q == '0)) begin
                count_d = '0;
                state_d = IDLE;
            end else if (state_q != DONE) begin
                // IDLE and RUN both count, so the arming edge counts as one.
                if (at_last) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    state_d = mode_q ? DONE : RUN;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    state_d = RUN;
                end
            end
            // A DONE channel that is still enabled keeps its defaults:
            // count is held and tick stays 0.
        end

        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before the edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                div_q   <= CNT_W'(DEFAULT_DIV);
                count_q <= '0;
                mode_q  <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                div_q   <= div_d;
                count_q <= count_d;
                mode_q  <= mode_d;
                tick_q  <= tick_d;
            end
        end

        assign tick[g] = tick_q;
        assign busy[g] = (state_q == RUN);
    end

endmodule

// File: tb/tb_prog_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_prog_tick_gen
//
// Scoreboard bench for prog_tick_gen (NUM_CH=4, CNT_W=8, DEFAULT_DIV=5).
// The stimulus process updates a behavioural model on each rising edge and
// queues the expected tick/busy vectors. The monitor pops the queue on each
// falling edge and compares it with the DUT outputs.
//
// The model tracks, per channel, how many enabled counting edges have occurred
// since the channel was last armed:
//   - Periodic mode ticks whenever that count is a multiple of div.
//   - One-shot mode ticks once, when the count equals div.
// -----------------------------------------------------------------------------
module tb_prog_tick_gen;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DDIV = 5;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] busy;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           sync;
    logic [NCH-1:0] enable;
    logic           cfg_wr;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_oneshot;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Reference model state.
    int             m_div [NCH];
    bit             m_one [NCH];
    int             m_k   [NCH];
    logic [NCH-1:0] m_busy;

    always #5 clk = ~clk;

    prog_tick_gen #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
`ifdef TICK_GEN_SYNC_EN
        .sync        (sync),
`endif
        .tick        (tick),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [NCH-1:0] act,
                         input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_init();
        for (int c = 0; c < NCH; c++) begin
            m_div[c] = DDIV;
            m_one[c] = 1'b0;
            m_k[c]   = 0;
        end
        m_busy = '0;
    endtask

    // Applies one rising edge to the model and queues the expected outputs.
    task automatic model_edge();
        exp_t e;
        e = '0;
        if (reset) begin
            model_init();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_wr && (int'(cfg_ch) == c)) begin
                    m_div[c] = int'(cfg_div);
                    m_one[c] = cfg_oneshot;
                    m_k[c]   = 0;
                end else if (sync) begin
                    m_k[c]    = 0;
                    e.busy[c] = m_busy[c];
                end else if (!enable[c] || m_div[c] == 0) begin
                    m_k[c] = 0;
                end else if (m_one[c] && m_k[c] >= m_div[c]) begin
                    // One-shot already fired: the channel stays silent.
                end else begin
                    m_k[c]++;
                    e.tick[c] = (m_k[c] % m_div[c]) == 0;
                    e.busy[c] = m_one[c] ? (m_k[c] < m_div[c]) : 1'b1;
                end
            end
        end
        m_busy = e.busy;
        exp_q.push_back(e);
    endtask

    // Each cycle: apply the edge to the model, then return 2 time units after
    // the edge so the caller can change inputs for the next edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #2;
        end
    endtask

    task automatic cfg(input int ch, input int div, input bit one);
        cfg_wr      = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_div     = CW'(div);
        cfg_oneshot = one;
        run(1);
        cfg_wr      = 1'b0;
    endtask

    // Monitor: compares the DUT outputs against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick", tick, e.tick);
                check("busy", busy, e.busy);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        sync        = 1'b0;
        enable      = '0;
        cfg_wr      = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        cfg_oneshot = 1'b0;
        model_init();
        #1;
        check("reset_tick", tick, '0);
        check("reset_busy", busy, '0);
        run(2);
        reset = 1'b0;
        run(1);

        // Periodic channel 0 with the default divisor.
        enable[0] = 1'b1;
        run(16);

        // One-shot channel 1, then re-arm by dropping enable for one cycle.
        cfg(1, 3, 1'b1);
        enable[1] = 1'b1;
        run(25);
        enable[1] = 1'b0;
        run(1);
        enable[1] = 1'b1;
        run(6);

        // div=1 holds tick high; div=0 makes the channel inert.
        cfg(2, 1, 1'b0);
        enable[2] = 1'b1;
        run(5);
        cfg(2, 0, 1'b0);
        run(8);

        // A write on the count==div-1 edge suppresses that tick.
        enable[3] = 1'b1;
        run(4);
        cfg(3, 4, 1'b0);
        run(10);

        // Asynchronous reset in the middle of a count.
        enable = 4'b0001;
        run(7);
        #4;
        reset = 1'b1;
        #1;
        check("async_rst_tick", tick, '0);
        check("async_rst_busy", busy, '0);
        model_init();
        run(1);
        reset = 1'b0;
        run(12);

`ifdef TICK_GEN_SYNC_EN
        // Two channels with equal divisors, out of phase, realigned by sync.
        enable = '0;
        cfg(0, 4, 1'b0);
        cfg(1, 4, 1'b0);
        enable[0] = 1'b1;
        run(2);
        enable[1] = 1'b1;
        run(5);
        sync = 1'b1;
        run(1);
        sync = 1'b0;
        run(13);
`endif

        // Randomized traffic: enable changes, config writes, small divisors.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) enable = NCH'($urandom);
`ifdef TICK_GEN_SYNC_EN
            sync = ($urandom_range(0, 39) == 0);
`endif
            if ($urandom_range(0, 7) == 0)
                cfg(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)));
            else
                run(1);
        end
        sync = 1'b0;

        // Let the monitor drain the queue, then confirm nothing was left.
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
